// File: rtl/dsp_lane_arbiter.sv
// Round-robin arbiter that packs up to two requesters per cycle into the two
// lanes of a shared SIMD DSP unit and routes the results back by tag.
module dsp_lane_arbiter #(
   parameter int unsigned width   = 24,
   parameter int unsigned nreq    = 4,
   parameter int unsigned latency = 0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [nreq-1:0]         req_valid,
   output logic [nreq-1:0]         req_ready,
   input  logic [nreq*width-1:0]   req_a,
   input  logic [nreq*width-1:0]   req_b,
   output logic [nreq-1:0]         rsp_valid,
   output logic [nreq*width-1:0]   rsp_y,
   output logic [width-1:0]        dsp_a0,
   output logic [width-1:0]        dsp_b0,
   output logic [width-1:0]        dsp_a1,
   output logic [width-1:0]        dsp_b1,
   input  logic [width-1:0]        dsp_y0,
   input  logic [width-1:0]        dsp_y1,
   output logic                    idle
);

   localparam int unsigned IDW = (nreq > 1) ? $clog2(nreq) : 1;
   localparam logic [IDW-1:0] LAST_ID = IDW'(nreq - 1);

   if (width == 0 || width > 24) begin : g_bad_width
      $error("dsp_lane_arbiter: width must be in 1..24");
   end
   if (nreq < 2 || nreq > 8) begin : g_bad_nreq
      $error("dsp_lane_arbiter: nreq must be in 2..8");
   end
   if (latency > 4) begin : g_bad_latency
      $error("dsp_lane_arbiter: latency must be in 0..4");
   end

   typedef struct packed {
      logic           v0;
      logic [IDW-1:0] id0;
      logic           v1;
      logic [IDW-1:0] id1;
   } tag_t;

   function automatic logic [IDW-1:0] f_next(input logic [IDW-1:0] x);
      return (x == LAST_ID) ? '0 : x + IDW'(1);
   endfunction

   logic [IDW-1:0]   r_ptr;
   logic             r_idle;
   logic [nreq-1:0]  r_rsp_valid;
   logic [width-1:0] r_rsp_y [nreq];

   logic [width-1:0] w_a [nreq];
   logic [width-1:0] w_b [nreq];
   logic             w_g0;
   logic             w_g1;
   logic [IDW-1:0]   w_idx0;
   logic [IDW-1:0]   w_idx1;
   logic [IDW-1:0]   w_scan;
   tag_t             w_cur;
   tag_t             w_head;
   logic             w_tag_busy;
   logic [nreq-1:0]  w_rsp_valid_nxt;

   for (genvar g = 0; g < int'(nreq); g++) begin : g_slice
      assign w_a[g]                    = req_a[g*width +: width];
      assign w_b[g]                    = req_b[g*width +: width];
      assign rsp_y[g*width +: width]   = r_rsp_y[g];
   end

   // Lane0 scans from ptr; lane1 scans from the slot after lane0 and stops short of it.
   always_comb begin
      w_g0   = 1'b0;
      w_idx0 = '0;
      w_g1   = 1'b0;
      w_idx1 = '0;
      w_scan = r_ptr;
      for (int k = 0; k < int'(nreq); k++) begin
         if (!w_g0 && req_valid[w_scan]) begin
            w_g0   = 1'b1;
            w_idx0 = w_scan;
         end
         w_scan = f_next(w_scan);
      end
      w_scan = f_next(w_idx0);
      for (int k = 1; k < int'(nreq); k++) begin
         if (w_g0 && !w_g1 && req_valid[w_scan]) begin
            w_g1   = 1'b1;
            w_idx1 = w_scan;
         end
         w_scan = f_next(w_scan);
      end
   end

   always_comb begin
      req_ready = '0;
      if (w_g0) req_ready[w_idx0] = 1'b1;
      if (w_g1) req_ready[w_idx1] = 1'b1;
   end

   assign dsp_a0 = w_g0 ? w_a[w_idx0] : '0;
   assign dsp_b0 = w_g0 ? w_b[w_idx0] : '0;
   assign dsp_a1 = w_g1 ? w_a[w_idx1] : '0;
   assign dsp_b1 = w_g1 ? w_b[w_idx1] : '0;

   always_comb begin
      w_cur     = '0;
      w_cur.v0  = w_g0;
      w_cur.id0 = w_idx0;
      w_cur.v1  = w_g1;
      w_cur.id1 = w_idx1;
   end

   // Tag stages mirror the DSP pipeline so the head lines up with dsp_y0/dsp_y1.
   if (latency == 0) begin : g_comb_tag
      assign w_head     = w_cur;
      assign w_tag_busy = 1'b0;
   end else begin : g_pipe_tag
      tag_t r_tag [latency];

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            for (int i = 0; i < int'(latency); i++) r_tag[i] <= '0;
         end else begin
            r_tag[0] <= w_cur;
            for (int i = 1; i < int'(latency); i++) r_tag[i] <= r_tag[i-1];
         end
      end

      always_comb begin
         w_tag_busy = 1'b0;
         for (int i = 0; i < int'(latency); i++) begin
            w_tag_busy = w_tag_busy | r_tag[i].v0 | r_tag[i].v1;
         end
      end

      assign w_head = r_tag[latency-1];
   end

   always_comb begin
      w_rsp_valid_nxt = '0;
      if (w_head.v0) w_rsp_valid_nxt[w_head.id0] = 1'b1;
      if (w_head.v1) w_rsp_valid_nxt[w_head.id1] = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ptr  <= '0;
         r_idle <= 1'b1;
      end else begin
         if (w_g1)      r_ptr <= f_next(w_idx1);
         else if (w_g0) r_ptr <= f_next(w_idx0);
         // Next cycle is busy if anything enters or still sits in the tag pipe.
         r_idle <= !(w_cur.v0 || w_tag_busy);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rsp_valid <= '0;
         for (int i = 0; i < int'(nreq); i++) r_rsp_y[i] <= '0;
      end else begin
         r_rsp_valid <= w_rsp_valid_nxt;
         if (w_head.v0) r_rsp_y[w_head.id0] <= dsp_y0;
         if (w_head.v1) r_rsp_y[w_head.id1] <= dsp_y1;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign idle      = r_idle;

endmodule

// File: tb/tb_dsp_lane_arbiter.sv
// Scoreboard bench: three arbiters (latency 0, 2, 3) share one stimulus stream,
// each with an OR-based DSP model; a negedge monitor retires expected results.
module tb_dsp_lane_arbiter;

   localparam int unsigned W = 24;
   localparam int unsigned N = 4;
   localparam logic [95:0] DA = {24'hA0A003, 24'h5A0002, 24'h00C301, 24'h800000};
   localparam logic [95:0] DB = {24'h0B0B00, 24'h005A50, 24'h3C0010, 24'h000F0F};

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_a = '0;
   logic [N*W-1:0] req_b = '0;

   logic [N-1:0]   rdy [3];
   logic [N-1:0]   rv  [3];
   logic [N*W-1:0] ry  [3];
   logic           idl [3];
   logic [W-1:0]   da0 [3];
   logic [W-1:0]   db0 [3];
   logic [W-1:0]   da1 [3];
   logic [W-1:0]   db1 [3];
   logic [W-1:0]   dy0 [3];
   logic [W-1:0]   dy1 [3];

   typedef struct {
      int         inst;
      int         due;
      int         id;
      logic [W-1:0] y;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   dsp_lane_arbiter #(.width(W), .nreq(N), .latency(0)) u_l0 (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rv[0]), .rsp_y(ry[0]),
      .dsp_a0(da0[0]), .dsp_b0(db0[0]), .dsp_a1(da1[0]), .dsp_b1(db1[0]),
      .dsp_y0(dy0[0]), .dsp_y1(dy1[0]), .idle(idl[0]));

   dsp_lane_arbiter #(.width(W), .nreq(N), .latency(2)) u_l2 (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rv[1]), .rsp_y(ry[1]),
      .dsp_a0(da0[1]), .dsp_b0(db0[1]), .dsp_a1(da1[1]), .dsp_b1(db1[1]),
      .dsp_y0(dy0[1]), .dsp_y1(dy1[1]), .idle(idl[1]));

   dsp_lane_arbiter #(.width(W), .nreq(N), .latency(3)) u_l3 (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy[2]),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rv[2]), .rsp_y(ry[2]),
      .dsp_a0(da0[2]), .dsp_b0(db0[2]), .dsp_a1(da1[2]), .dsp_b1(db1[2]),
      .dsp_y0(dy0[2]), .dsp_y1(dy1[2]), .idle(idl[2]));

   // DSP lane models: bitwise OR with 0, 2 and 3 register stages.
   logic [W-1:0] p2_0 [2];
   logic [W-1:0] p2_1 [2];
   logic [W-1:0] p3_0 [3];
   logic [W-1:0] p3_1 [3];

   assign dy0[0] = da0[0] | db0[0];
   assign dy1[0] = da1[0] | db1[0];

   always @(posedge clock) begin
      p2_0[0] <= da0[1] | db0[1];
      p2_1[0] <= da1[1] | db1[1];
      p2_0[1] <= p2_0[0];
      p2_1[1] <= p2_1[0];
      p3_0[0] <= da0[2] | db0[2];
      p3_1[0] <= da1[2] | db1[2];
      p3_0[1] <= p3_0[0];
      p3_1[1] <= p3_1[0];
      p3_0[2] <= p3_0[1];
      p3_1[2] <= p3_1[1];
   end

   assign dy0[1] = p2_0[1];
   assign dy1[1] = p2_1[1];
   assign dy0[2] = p3_0[2];
   assign dy1[2] = p3_1[2];

   function automatic int lat_of(input int k);
      return (k == 0) ? 0 : (k == 1) ? 2 : 3;
   endfunction

   function automatic logic [95:0] mk(input logic [W-1:0] s3, input logic [W-1:0] s2,
                                      input logic [W-1:0] s1, input logic [W-1:0] s0);
      return {s3, s2, s1, s0};
   endfunction

   task automatic check(input string name, input int k, input logic [95:0] act,
                        input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut_lat%0d cycle %0d: got %h expected %h",
                  name, lat_of(k), cyc, act, exp);
      end
   endtask

   // Drive one cycle of requests, check the combinational grant, queue the expected results.
   task automatic issue(input logic [N-1:0] v, input logic [95:0] a, input logic [95:0] b,
                        input logic [N-1:0] exp_rdy, input int l0, input int l1);
      logic [W-1:0] ea0, eb0, ea1, eb1;
      exp_t e;
      @(negedge clock);
      req_valid = v;
      req_a     = a;
      req_b     = b;
      #1;
      ea0 = '0; eb0 = '0; ea1 = '0; eb1 = '0;
      if (l0 >= 0) begin ea0 = a[l0*W +: W]; eb0 = b[l0*W +: W]; end
      if (l1 >= 0) begin ea1 = a[l1*W +: W]; eb1 = b[l1*W +: W]; end
      for (int k = 0; k < 3; k++) begin
         check("req_ready", k, 96'(rdy[k]), 96'(exp_rdy));
         check("dsp_a0", k, 96'(da0[k]), 96'(ea0));
         check("dsp_b0", k, 96'(db0[k]), 96'(eb0));
         check("dsp_a1", k, 96'(da1[k]), 96'(ea1));
         check("dsp_b1", k, 96'(db1[k]), 96'(eb1));
         if (l0 >= 0) begin
            e.inst = k; e.due = cyc + lat_of(k) + 1; e.id = l0; e.y = ea0 | eb0;
            q.push_back(e);
         end
         if (l1 >= 0) begin
            e.inst = k; e.due = cyc + lat_of(k) + 1; e.id = l1; e.y = ea1 | eb1;
            q.push_back(e);
         end
      end
   endtask

   task automatic quiet(input int n);
      for (int i = 0; i < n; i++) issue('0, '0, '0, '0, -1, -1);
   endtask

   // Monitor: retire every entry due this cycle, then demand rsp_valid equals exactly those ids.
   always @(negedge clock) begin : monitor
      logic [N-1:0] mask;
      logic         busy;
      int           i;
      for (int k = 0; k < 3; k++) begin
         busy = 1'b0;
         foreach (q[j]) begin
            if (q[j].inst == k && q[j].due - lat_of(k) <= cyc) busy = 1'b1;
         end
         check("idle", k, 96'(idl[k]), 96'(!busy));
         mask = '0;
         i = 0;
         while (i < q.size()) begin
            if (q[i].inst == k && q[i].due == cyc) begin
               check("rsp_y", k, 96'(ry[k][q[i].id*W +: W]), 96'(q[i].y));
               mask[q[i].id] = 1'b1;
               q.delete(i);
            end else begin
               i++;
            end
         end
         check("rsp_valid", k, 96'(rv[k]), 96'(mask));
      end
   end

   initial begin
      #1 reset = 1'b1;
      @(negedge clock);
      #1;
      for (int k = 0; k < 3; k++) check("reset_rsp_y", k, ry[k], '0);
      @(negedge clock);
      #2 reset = 1'b0;

      // Single request on requester 2, ptr=0: lane0 only, result FF0F0F.
      issue(4'b0100, mk(24'h0, 24'h0F0F0F, 24'h0, 24'h0),
                     mk(24'h0, 24'hF00000, 24'h0, 24'h0), 4'b0100, 2, -1);
      // No requests for five cycles: ptr must stay at 3.
      quiet(5);
      issue(4'b1111, DA, DB, 4'b1001, 3, 0);
      issue(4'b1000, DA, DB, 4'b1000, 3, -1);
      // Dual issue from ptr=0 across two cycles.
      issue(4'b1111, DA, DB, 4'b0011, 0, 1);
      issue(4'b1111, ~DA, DB, 4'b1100, 2, 3);
      // Requesters 0 and 3 both served every cycle.
      for (int i = 0; i < 6; i++) issue(4'b1001, DA ^ 96'(i), DB, 4'b1001, 0, 3);
      // Only requester 3 from ptr=0: wrap-around grant.
      issue(4'b1000, DA, DB, 4'b1000, 3, -1);
      // Back-to-back grants to requester 1, results in issue order.
      issue(4'b0010, mk(24'h0, 24'h0, 24'h1, 24'h0), '0, 4'b0010, 1, -1);
      issue(4'b0010, mk(24'h0, 24'h0, 24'h2, 24'h0), '0, 4'b0010, 1, -1);
      issue(4'b0010, mk(24'h0, 24'h0, 24'h4, 24'h0), '0, 4'b0010, 1, -1);
      quiet(5);
      // Lane1 wrapping below lane0, from various ptr values.
      issue(4'b0110, DA, DB, 4'b0110, 2, 1);
      issue(4'b0111, DB, DA, 4'b0101, 2, 0);
      issue(4'b0101, DA, ~DB, 4'b0101, 2, 0);
      issue(4'b0111, DA, DB, 4'b0110, 1, 2);
      // Grant 0 and 2, then reset while they are in flight.
      issue(4'b0101, DA, DB, 4'b0101, 0, 2);
      @(negedge clock);
      #2;
      reset     = 1'b1;
      req_valid = '0;
      q.delete();
      #1;
      for (int k = 0; k < 3; k++) begin
         check("reset_rsp_valid", k, 96'(rv[k]), '0);
         check("reset_rsp_y", k, ry[k], '0);
         check("reset_idle", k, 96'(idl[k]), 96'(1));
      end
      @(negedge clock);
      #2 reset = 1'b0;
      // ptr back at 0: lane0 takes 1, lane1 takes 3.
      issue(4'b1010, DA, DB, 4'b1010, 1, 3);
      quiet(6);
      @(negedge clock);
      #1;
      check("drain", 0, 96'(q.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
